// File: rtl/alu_dispatch.sv
// Dispatches one RV32I OP / OP-IMM / BRANCH instruction at a time to an external
// multi-cycle ALU and returns the captured result through a valid/ready response.
module alu_dispatch #(
   parameter int unsigned ALU_LATENCY = 3
) (
   input  logic        soc_clk,
   input  logic        reset_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_instr,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   output logic [31:0] ALU_dat1,
   output logic [31:0] ALU_dat2,
   output logic [2:0]  ALU_opcode,
   output logic        ALU_opcode_differentiator,
   output logic        ALU_optype,
   output logic        dat_ready,
   input  logic [31:0] ALU_out,
   input  logic        ALU_overflow,
   input  logic        ALU_branch,
   input  logic        ALU_zero,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_branch,
   output logic        rsp_zero,
   output logic        rsp_overflow,
   output logic        rsp_error
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [3:0] LAT        = 4'(ALU_LATENCY);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] dat1_q, dat1_d, dat2_q, dat2_d;
   logic [2:0]  opcode_q, opcode_d;
   logic        diff_q, diff_d, optype_q, optype_d, dat_ready_q, dat_ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_result_q, rsp_result_d;
   logic        rsp_branch_q, rsp_branch_d, rsp_zero_q, rsp_zero_d;
   logic        rsp_overflow_q, rsp_overflow_d, rsp_error_q, rsp_error_d;

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic        is_op, is_imm, is_br, legal;
   logic [31:0] dec_dat2;
   logic        dec_diff;
   logic        unused_instr_bits;

   assign opc    = req_instr[6:0];
   assign f3     = req_instr[14:12];
   assign is_op  = (opc == OPC_OP);
   assign is_imm = (opc == OPC_OP_IMM);
   assign is_br  = (opc == OPC_BRANCH);
   assign legal  = is_op || is_imm || (is_br && (f3 != 3'b010) && (f3 != 3'b011));
   assign unused_instr_bits = ^{req_instr[19:15], req_instr[11:7]};

   // Shift-immediates carry a 5-bit shamt; every other immediate is sign-extended.
   always_comb begin
      dec_dat2 = req_rs2;
      if (is_imm) begin
         if (f3 == 3'b001 || f3 == 3'b101) dec_dat2 = {27'd0, req_instr[24:20]};
         else                              dec_dat2 = {{20{req_instr[31]}}, req_instr[31:20]};
      end
      dec_diff = 1'b0;
      if ((is_op && (f3 == 3'b000 || f3 == 3'b101)) || (is_imm && f3 == 3'b101))
         dec_diff = req_instr[30];
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      dat1_d         = dat1_q;
      dat2_d         = dat2_q;
      opcode_d       = opcode_q;
      diff_d         = diff_q;
      optype_d       = optype_q;
      dat_ready_d    = dat_ready_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_result_d   = rsp_result_q;
      rsp_branch_d   = rsp_branch_q;
      rsp_zero_d     = rsp_zero_q;
      rsp_overflow_d = rsp_overflow_q;
      rsp_error_d    = rsp_error_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && legal) begin
               state_d     = ST_BUSY;
               cnt_d       = LAT;
               dat1_d      = req_rs1;
               dat2_d      = dec_dat2;
               opcode_d    = f3;
               diff_d      = dec_diff;
               optype_d    = is_br;
               dat_ready_d = 1'b1;
            end else if (req_valid) begin
               state_d        = ST_RESP;
               rsp_valid_d    = 1'b1;
               rsp_error_d    = 1'b1;
               rsp_result_d   = 32'd0;
               rsp_branch_d   = 1'b0;
               rsp_zero_d     = 1'b0;
               rsp_overflow_d = 1'b0;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               // optype_q still identifies a branch on this final edge.
               state_d        = ST_RESP;
               rsp_valid_d    = 1'b1;
               rsp_error_d    = 1'b0;
               rsp_result_d   = optype_q ? 32'd0 : ALU_out;
               rsp_branch_d   = optype_q & ALU_branch;
               rsp_zero_d     = ALU_zero;
               rsp_overflow_d = ~optype_q & ALU_overflow;
               dat1_d         = 32'd0;
               dat2_d         = 32'd0;
               opcode_d       = 3'd0;
               diff_d         = 1'b0;
               optype_d       = 1'b0;
               dat_ready_d    = 1'b0;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d        = ST_IDLE;
               rsp_valid_d    = 1'b0;
               rsp_result_d   = 32'd0;
               rsp_branch_d   = 1'b0;
               rsp_zero_d     = 1'b0;
               rsp_overflow_d = 1'b0;
               rsp_error_d    = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge soc_clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q        <= ST_IDLE;
         cnt_q          <= 4'd0;
         dat1_q         <= 32'd0;
         dat2_q         <= 32'd0;
         opcode_q       <= 3'd0;
         diff_q         <= 1'b0;
         optype_q       <= 1'b0;
         dat_ready_q    <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_result_q   <= 32'd0;
         rsp_branch_q   <= 1'b0;
         rsp_zero_q     <= 1'b0;
         rsp_overflow_q <= 1'b0;
         rsp_error_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         dat1_q         <= dat1_d;
         dat2_q         <= dat2_d;
         opcode_q       <= opcode_d;
         diff_q         <= diff_d;
         optype_q       <= optype_d;
         dat_ready_q    <= dat_ready_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_result_q   <= rsp_result_d;
         rsp_branch_q   <= rsp_branch_d;
         rsp_zero_q     <= rsp_zero_d;
         rsp_overflow_q <= rsp_overflow_d;
         rsp_error_q    <= rsp_error_d;
      end
   end

   // Ready is gated by reset so the control unit sees 0 while reset_b is low.
   assign req_ready                 = (state_q == ST_IDLE) && reset_b;
   assign ALU_dat1                  = dat1_q;
   assign ALU_dat2                  = dat2_q;
   assign ALU_opcode                = opcode_q;
   assign ALU_opcode_differentiator = diff_q;
   assign ALU_optype                = optype_q;
   assign dat_ready                 = dat_ready_q;
   assign rsp_valid                 = rsp_valid_q;
   assign rsp_result                = rsp_result_q;
   assign rsp_branch                = rsp_branch_q;
   assign rsp_zero                  = rsp_zero_q;
   assign rsp_overflow              = rsp_overflow_q;
   assign rsp_error                 = rsp_error_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: expected responses are queued at request
// time and compared when the DUT raises rsp_valid.
module tb_alu_dispatch;

   localparam int LAT = 3;

   logic        soc_clk = 1'b0;
   logic        reset_b;
   logic        req_valid, req_ready;
   logic [31:0] req_instr, req_rs1, req_rs2;
   logic [31:0] ALU_dat1, ALU_dat2;
   logic [2:0]  ALU_opcode;
   logic        ALU_opcode_differentiator, ALU_optype, dat_ready;
   logic [31:0] ALU_out;
   logic        ALU_overflow, ALU_branch, ALU_zero;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_branch, rsp_zero, rsp_overflow, rsp_error;

   typedef struct packed {
      logic [31:0] result;
      logic        branch;
      logic        zero;
      logic        overflow;
      logic        error;
   } rsp_t;

   rsp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 soc_clk = ~soc_clk;

   alu_dispatch #(.ALU_LATENCY(LAT)) dut (
      .soc_clk(soc_clk), .reset_b(reset_b),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_instr(req_instr), .req_rs1(req_rs1), .req_rs2(req_rs2),
      .ALU_dat1(ALU_dat1), .ALU_dat2(ALU_dat2), .ALU_opcode(ALU_opcode),
      .ALU_opcode_differentiator(ALU_opcode_differentiator),
      .ALU_optype(ALU_optype), .dat_ready(dat_ready),
      .ALU_out(ALU_out), .ALU_overflow(ALU_overflow),
      .ALU_branch(ALU_branch), .ALU_zero(ALU_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_branch(rsp_branch), .rsp_zero(rsp_zero),
      .rsp_overflow(rsp_overflow), .rsp_error(rsp_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] instr, rs1, rs2, aout,
                         input logic abr, azero, aovf,
                         input logic [31:0] e_dat2, input logic [2:0] e_opc,
                         input logic e_diff, e_opt, e_legal, input int hold);
      rsp_t e, got;
      int   n, dr;
      e.result   = (!e_legal || e_opt) ? 32'd0 : aout;
      e.branch   = e_legal && e_opt && abr;
      e.zero     = e_legal && azero;
      e.overflow = e_legal && !e_opt && aovf;
      e.error    = !e_legal;
      sb_q.push_back(e);

      @(negedge soc_clk);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_instr = instr; req_rs1 = rs1; req_rs2 = rs2;
      ALU_out = aout; ALU_branch = abr; ALU_zero = azero; ALU_overflow = aovf;
      @(posedge soc_clk); #1;
      req_valid = 1'b0; req_instr = 32'h0; req_rs1 = ~rs1; req_rs2 = ~rs2;

      n = 0; dr = 0;
      do begin
         @(negedge soc_clk); n++;
         if (dat_ready) begin
            dr++;
            chk("ALU_dat1", ALU_dat1, rs1);
            chk("ALU_dat2", ALU_dat2, e_dat2);
            chk("ALU_opcode", {29'd0, ALU_opcode}, {29'd0, e_opc});
            chk("ALU_diff", {31'd0, ALU_opcode_differentiator}, {31'd0, e_diff});
            chk("ALU_optype", {31'd0, ALU_optype}, {31'd0, e_opt});
            chk("req_ready_busy", req_ready, 0);
         end
      end while (!rsp_valid && n < 40);
      chk("rsp_latency", n, e_legal ? LAT + 1 : 1);
      chk("dat_ready_cycles", dr, e_legal ? LAT : 0);
      chk("bus_cleared", ALU_dat1 | ALU_dat2, 0);

      got = sb_q.pop_front();
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", rsp_valid, 1);
         chk("hold_result", rsp_result, got.result);
         chk("hold_error", rsp_error, got.error);
         @(negedge soc_clk);
      end
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_result", rsp_result, got.result);
      chk("rsp_flags", {rsp_branch, rsp_zero, rsp_overflow, rsp_error},
          {got.branch, got.zero, got.overflow, got.error});

      // Handshake with a competing request present: it must not be taken.
      rsp_ready = 1'b1; req_valid = 1'b1; req_instr = 32'h00500093;
      @(posedge soc_clk); #1;
      rsp_ready = 1'b0;
      @(negedge soc_clk);
      chk("rsp_valid_cleared", rsp_valid, 0);
      chk("rsp_fields_cleared", rsp_result | {28'd0, rsp_branch, rsp_zero, rsp_overflow, rsp_error}, 0);
      chk("bubble_no_accept", dat_ready, 0);
      chk("req_ready_after", req_ready, 1);
      req_valid = 1'b0;
   endtask

   initial begin
      reset_b = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_instr = 32'h0; req_rs1 = 32'h0; req_rs2 = 32'h0;
      ALU_out = 32'h0; ALU_overflow = 1'b0; ALU_branch = 1'b0; ALU_zero = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_dat_ready", dat_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      repeat (2) @(negedge soc_clk);
      reset_b = 1'b1; #1;
      chk("post_rst_req_ready", req_ready, 1);

      //     instr         rs1           rs2           aout          br zr ov  dat2          opc   df opt lg hold
      run_op(32'h00500093, 32'd10,       32'd0,        32'd15,       0, 0, 0, 32'd5,        3'd0, 0, 0, 1, 0);
      run_op(32'h40208033, 32'd7,        32'd9,        32'hFFFFFFFE, 0, 0, 1, 32'd9,        3'd0, 1, 0, 1, 2);
      run_op(32'h4030D093, 32'h80000000, 32'd0,        32'hF0000000, 0, 0, 0, 32'd3,        3'd5, 1, 0, 1, 0);
      run_op(32'hFFF00093, 32'd1,        32'd0,        32'd0,        0, 1, 0, 32'hFFFFFFFF, 3'd0, 0, 0, 1, 0);
      run_op(32'h0020D0B3, 32'hF0,       32'd4,        32'h0F,       0, 0, 0, 32'd4,        3'd5, 0, 0, 1, 0);
      run_op(32'h00309093, 32'd1,        32'd0,        32'd8,        0, 0, 0, 32'd3,        3'd1, 0, 0, 1, 0);
      run_op(32'h00208463, 32'd5,        32'd5,        32'h1234,     1, 1, 1, 32'd5,        3'd0, 0, 1, 1, 1);
      run_op(32'h0000007F, 32'd3,        32'd4,        32'hAAAA,     1, 1, 1, 32'd0,        3'd0, 0, 0, 0, 5);
      run_op(32'h0020A463, 32'd3,        32'd4,        32'h5555,     1, 0, 0, 32'd0,        3'd0, 0, 0, 0, 0);

      // Reset one cycle into an operation discards it.
      @(negedge soc_clk);
      req_valid = 1'b1; req_instr = 32'h00500093; req_rs1 = 32'd10; ALU_out = 32'd15;
      @(posedge soc_clk); #1;
      req_valid = 1'b0;
      @(negedge soc_clk);
      chk("pre_rst_dat_ready", dat_ready, 1);
      reset_b = 1'b0; #1;
      chk("mid_rst_dat_ready", dat_ready, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_dat1", ALU_dat1, 0);
      @(negedge soc_clk);
      reset_b = 1'b1; #1;
      chk("mid_rst_req_ready", req_ready, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge soc_clk);
         chk("no_stale_rsp", {rsp_valid, dat_ready}, 0);
      end

      run_op(32'h40208033, 32'd20,       32'd5,        32'd15,       0, 0, 0, 32'd5,        3'd0, 1, 0, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got 0x00000000 expected 0x00000001");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter: ALU_LATENCY, 3, soc_clk cycles dat_ready is held high per operation (legal 1..15).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 soc_clk  in  1  clock; all state updates on its rising edge.
REQ-004 reset_b  in  1  asynchronous active-low reset.
REQ-005 req_valid / req_ready  in / out  1 / 1  request handshake from control unit.
REQ-006 req_instr  in  32  RV32I instruction word.
REQ-007 req_rs1, req_rs2  in  32 each  register operand values.
REQ-008 ALU_dat1, ALU_dat2  out  32 each  operands to ALU.
REQ-009 ALU_opcode  out  3  instr[14:12].
REQ-010 ALU_opcode_differentiator  out  1  1 = SUB/SRA/SRAI.
REQ-011 ALU_optype  out  1  1 = branch compare, 0 = I/R arithmetic.
REQ-012 dat_ready  out  1  operands valid to ALU.
REQ-013 ALU_out  in  32; ALU_overflow, ALU_branch, ALU_zero  in  1 each  ALU results.
REQ-014 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-015 rsp_result  out  32; rsp_branch, rsp_zero, rsp_overflow, rsp_error  out  1 each  captured response.

Function
REQ-016 States: IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE & req_valid & legal opcode: go to BUSY; on the same edge register ALU bus fields, set dat_ready = 1, load counter = ALU_LATENCY.
REQ-018 Legal opcodes: OP (0110011), OP-IMM (0010011), BRANCH (1100011) with funct3 not 010/011; all others illegal.
REQ-019 IDLE & req_valid & illegal: go to RESP next edge with rsp_error = 1, rsp_result = 0, flags 0; dat_ready never asserts.
REQ-020 ALU_dat1 = req_rs1 for all legal ops.
REQ-021 ALU_dat2 = req_rs2 for OP/BRANCH; OP-IMM funct3 001/101: zero-extended instr[24:20]; other OP-IMM: sign-extended instr[31:20].
REQ-022 Differentiator = instr[30] for OP funct3 000/101 and OP-IMM funct3 101; else 0 (ADDI with negative imm forced 0).
REQ-023 ALU_optype = 1 for BRANCH, 0 otherwise.
REQ-024 ALU bus fields are stable while dat_ready = 1; in IDLE/RESP they hold 0.
REQ-025 BUSY: counter decrements each edge; on the edge where counter = 1, capture ALU_out and flags, clear dat_ready, enter RESP, set rsp_valid.
REQ-026 dat_ready high exactly ALU_LATENCY cycles; rsp_valid rises ALU_LATENCY edges after the accept edge.
REQ-027 For BRANCH, rsp_result = 0 and rsp_overflow = 0; rsp_branch = captured ALU_branch. For I/R, rsp_branch = 0.
REQ-028 RESP: outputs held stable until rsp_valid & rsp_ready; then IDLE, rsp_valid = 0, response fields cleared.
REQ-029 No new request accepted in RESP even if rsp_ready is high the same cycle (one-cycle bubble).
REQ-030 req_valid changes while BUSY/RESP are ignored; captured operands are not re-sampled.

Reset
REQ-031 reset_b low asynchronously forces IDLE, counter 0, all outputs 0 (req_ready = 0 while in reset) regardless of state.
REQ-032 Reset during BUSY drops dat_ready immediately; the in-flight operation is discarded with no response.
REQ-033 After reset_b release, req_ready = 1 from the first cycle.

Verification
REQ-034 ADDI 0x00500093, rs1 = 10, ALU model returns 15 -> ALU_dat2 = 5, opcode 000, diff 0, optype 0; dat_ready high 3 cycles; rsp_result = 15 on the 3rd edge after accept.
REQ-035 SUB 0x40208033, rs1 = 7, rs2 = 9 -> ALU_dat2 = 9, diff 1; model returns 0xFFFFFFFE -> rsp_result = 0xFFFFFFFE.
REQ-036 SRAI 0x4030D093 -> ALU_dat2 = 3, opcode 101, diff 1; ADDI 0xFFF00093 -> ALU_dat2 = 0xFFFFFFFF, diff 0.
REQ-037 BEQ 0x00208463, ALU_branch = 1, ALU_out = 0x1234 -> optype 1; rsp_branch = 1, rsp_result = 0.
REQ-038 Illegal 0x0000007F -> rsp_valid one edge after accept, rsp_error = 1, dat_ready stays 0; rsp_ready held 0 for 5 cycles -> response stable.
REQ-039 reset_b low 1 cycle after accept -> dat_ready, rsp_valid = 0 immediately; after release req_ready = 1 and no stale response appears.
